// File: rtl/gpu_core_pkg.sv
// Shared definitions for the parametrised shader core: opcodes, FSM states
// and instruction-field slicing helpers.
package gpu_core_pkg;

    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned FIELD_W  = 4;
    localparam int unsigned NUM_REGS = 16;
    // One bit wider than the 4-bit target field so PC+1 past entry 15 is representable.
    localparam int unsigned PC_W     = 5;

    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RA_LSB  = 8;
    localparam int unsigned RB_LSB  = 4;
    localparam int unsigned RD_LSB  = 0;
    localparam int unsigned IMM_LSB = 4;
    localparam int unsigned IMM_W   = 8;
    localparam int unsigned CID_BIT = 11;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_MUL   = 4'd3;
    localparam logic [3:0] OP_DIV   = 4'd4;
    localparam logic [3:0] OP_CMPGE = 4'd5;
    localparam logic [3:0] OP_SHR   = 4'd6;
    localparam logic [3:0] OP_SHL   = 4'd7;
    localparam logic [3:0] OP_AND   = 4'd8;
    localparam logic [3:0] OP_OR    = 4'd9;
    localparam logic [3:0] OP_XOR   = 4'd10;
    localparam logic [3:0] OP_LD    = 4'd11;
    localparam logic [3:0] OP_LI    = 4'd12;
    localparam logic [3:0] OP_ST    = 4'd13;
    localparam logic [3:0] OP_BNZ   = 4'd14;
    localparam logic [3:0] OP_HALT  = 4'd15;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_MEM_WAIT,
        ST_WB
    } state_t;

    function automatic logic [FIELD_W-1:0] f_op(input logic [INSTR_W-1:0] ir);
        return ir[OP_LSB +: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] f_ra(input logic [INSTR_W-1:0] ir);
        return ir[RA_LSB +: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] f_rb(input logic [INSTR_W-1:0] ir);
        return ir[RB_LSB +: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] f_rd(input logic [INSTR_W-1:0] ir);
        return ir[RD_LSB +: FIELD_W];
    endfunction

    function automatic logic [IMM_W-1:0] f_imm(input logic [INSTR_W-1:0] ir);
        return ir[IMM_LSB +: IMM_W];
    endfunction

endpackage

// File: rtl/gpu_core_alu.sv
// Combinational ALU for the shader core.
// Ports: op (opcode), a/b (operands), result (DATA_W-wrapped result).
// Divide by zero yields all ones; shift amounts >= DATA_W yield zero.
module gpu_core_alu
    import gpu_core_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    logic shift_ovf;
    assign shift_ovf = (b >= DATA_W'(DATA_W));

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:   result = a + b;
            OP_SUB:   result = a - b;
            OP_MUL:   result = a * b;
            OP_DIV:   result = (b == '0) ? '1 : a / b;
            OP_CMPGE: result = DATA_W'(a >= b);
            OP_SHR:   result = shift_ovf ? '0 : (a >> b);
            OP_SHL:   result = shift_ovf ? '0 : (a << b);
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/gpu_core_param.sv
// Parametrised multi-cycle shader core: loads a program from the task
// scheduler, runs it through F/D/E/(M)/WB and reports completion on ready.
// Ports: clk, reset (async active-low); ins_valid/ins_last/instruction/rtr
// form the program-load interface; ready flags completion; core_id is the
// constant CORE_ID; mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_valid
// form the shared-memory request/completion handshake.
module gpu_core_param
    import gpu_core_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned IMEM_DEPTH = 16,
    parameter int unsigned SMEM_AW    = 12,
    parameter int unsigned CORE_ID    = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ins_valid,
    input  logic               ins_last,
    input  logic [15:0]        instruction,
    output logic               rtr,
    output logic               ready,
    output logic [3:0]         core_id,
    output logic               mem_req,
    output logic               mem_we,
    output logic [SMEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_valid
);

    localparam int unsigned     IDX_W    = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam logic [PC_W-1:0] LAST_IDX = PC_W'(IMEM_DEPTH - 1);
    localparam logic [3:0]      CID      = 4'(CORE_ID);

    state_t              state;
    logic [INSTR_W-1:0]  imem [IMEM_DEPTH];
    logic [DATA_W-1:0]   rf   [NUM_REGS];
    logic [INSTR_W-1:0]  ir;
    logic [PC_W-1:0]     pc;
    logic [PC_W-1:0]     ld_idx;
    logic [PC_W-1:0]     prog_len;
    logic [DATA_W-1:0]   res;

    logic [3:0]          op_c;
    logic [3:0]          ra_c;
    logic [3:0]          rb_c;
    logic [3:0]          rd_c;
    logic [DATA_W-1:0]   a_c;
    logic [DATA_W-1:0]   b_c;
    logic [DATA_W-1:0]   alu_res_c;
    logic [DATA_W-1:0]   exec_val_c;
    logic                is_mem_c;
    logic                writes_rd_c;
    logic [PC_W-1:0]     next_pc_c;
    logic                prog_end_c;

    assign core_id = CID;

    // Instruction decode and operand read from the latched IR.
    assign op_c = f_op(ir);
    assign ra_c = f_ra(ir);
    assign rb_c = f_rb(ir);
    assign rd_c = f_rd(ir);
    assign a_c  = rf[ra_c];
    assign b_c  = rf[rb_c];

    gpu_core_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (op_c),
        .a      (a_c),
        .b      (b_c),
        .result (alu_res_c)
    );

    // Value captured in EXEC for the later register write.
    always_comb begin
        exec_val_c = alu_res_c;
        if (op_c == OP_LI) begin
            exec_val_c = DATA_W'(f_imm(ir));
        end else if (op_c == OP_NOP) begin
            exec_val_c = DATA_W'(CID);
        end
    end

    assign is_mem_c    = (op_c == OP_LD) || (op_c == OP_ST);
    assign writes_rd_c = ((op_c >= OP_ADD) && (op_c <= OP_XOR)) || (op_c == OP_LD) ||
                         (op_c == OP_LI) || ((op_c == OP_NOP) && ir[CID_BIT]);

    // bnz reads A in WB; safe because bnz never writes the register file.
    assign next_pc_c  = ((op_c == OP_BNZ) && (a_c != '0)) ? PC_W'(rb_c) : pc + PC_W'(1);
    assign prog_end_c = (op_c == OP_HALT) || (next_pc_c >= prog_len);

    // Program store; not reset, contents persist until overwritten by the next load.
    always_ff @(posedge clk) begin
        if ((state == ST_LOAD) && ins_valid) begin
            imem[ld_idx[IDX_W-1:0]] <= instruction;
        end
    end

    // Control FSM, register file and registered memory-interface outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_LOAD;
            rtr       <= 1'b1;
            ready     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            pc        <= '0;
            ld_idx    <= '0;
            prog_len  <= '0;
            ir        <= '0;
            res       <= '0;
            rf        <= '{default: '0};
        end else begin
            case (state)
                ST_LOAD: begin
                    if (ins_valid) begin
                        ready  <= 1'b0;
                        ld_idx <= ld_idx + PC_W'(1);
                        if (ins_last || (ld_idx == LAST_IDX)) begin
                            prog_len <= ld_idx + PC_W'(1);
                            rtr      <= 1'b0;
                            pc       <= '0;
                            state    <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    ir    <= imem[pc[IDX_W-1:0]];
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    res <= exec_val_c;
                    if (is_mem_c) begin
                        // Request is visible from the MEM cycle onward and held until mem_valid.
                        mem_req  <= 1'b1;
                        mem_we   <= (op_c == OP_ST);
                        mem_addr <= SMEM_AW'({b_c, a_c});
                        if (op_c == OP_ST) begin
                            mem_wdata <= rf[rd_c];
                        end
                        state <= ST_MEM;
                    end else begin
                        state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    state <= ST_MEM_WAIT;
                end
                ST_MEM_WAIT: begin
                    if (mem_valid) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            res <= mem_rdata;
                        end
                        state <= ST_WB;
                    end
                end
                ST_WB: begin
                    if (writes_rd_c) begin
                        rf[rd_c] <= res;
                    end
                    if (prog_end_c) begin
                        ready  <= 1'b1;
                        rtr    <= 1'b1;
                        pc     <= '0;
                        ld_idx <= '0;
                        state  <= ST_LOAD;
                    end else begin
                        pc    <= next_pc_c;
                        state <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_core_param.sv
// Self-checking bench for gpu_core_param (DATA_W=8, IMEM_DEPTH=16,
// SMEM_AW=12, CORE_ID=9). Register contents are observed through stores.
module tb_gpu_core_param;

    typedef logic [7:0][15:0] prog_t;

    typedef struct packed {
        prog_t       prog;
        logic [3:0]  len;
        logic [7:0]  exp_data;
        logic [11:0] exp_addr;
        logic [7:0]  exp_cyc;
    } vec_t;

    localparam int NV = 16;

    logic        clk;
    logic        reset;
    logic        ins_valid;
    logic        ins_last;
    logic [15:0] instruction;
    logic        rtr;
    logic        ready;
    logic [3:0]  core_id;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_valid;

    int checks = 0;
    int errors = 0;

    int mem_delay = 1;
    bit resp_en = 1'b1;
    int seen = 0;
    int n_txn = 0;
    logic [11:0] t_addr  [8];
    logic        t_we    [8];
    logic [7:0]  t_wdata [8];
    int          t_cyc   [8];
    logic [7:0]  smem    [4096];

    vec_t vecs [NV];

    gpu_core_param #(
        .DATA_W     (8),
        .IMEM_DEPTH (16),
        .SMEM_AW    (12),
        .CORE_ID    (9)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ins_valid   (ins_valid),
        .ins_last    (ins_last),
        .instruction (instruction),
        .rtr         (rtr),
        .ready       (ready),
        .core_id     (core_id),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_valid   (mem_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rr(input logic [3:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rd);
        return {op, ra, rb, rd};
    endfunction

    function automatic logic [15:0] li(input logic [3:0] rd, input logic [7:0] imm);
        return {4'hC, imm, rd};
    endfunction

    function automatic vec_t mkv(input logic [15:0] w0, input logic [15:0] w1,
                                 input logic [15:0] w2, input logic [15:0] w3,
                                 input logic [3:0] len, input logic [7:0] d,
                                 input logic [11:0] a, input logic [7:0] cyc);
        vec_t v;
        v.prog     = '0;
        v.prog[0]  = w0;
        v.prog[1]  = w1;
        v.prog[2]  = w2;
        v.prog[3]  = w3;
        v.len      = len;
        v.exp_data = d;
        v.exp_addr = a;
        v.exp_cyc  = cyc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; samples 1 time unit after the edge and plays the memory model.
    task automatic tick();
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        if (!mem_req) begin
            seen = 0;
        end else if (resp_en) begin
            seen++;
            if (seen == mem_delay + 1) begin
                mem_valid = 1'b1;
                if (n_txn < 8) begin
                    t_addr[3'(n_txn)]  = mem_addr;
                    t_we[3'(n_txn)]    = mem_we;
                    t_wdata[3'(n_txn)] = mem_wdata;
                    t_cyc[3'(n_txn)]   = seen;
                end
                n_txn++;
                if (mem_we) smem[mem_addr] = mem_wdata;
                else        mem_rdata = smem[mem_addr];
            end
        end
    endtask

    task automatic load_prog(input prog_t p, input int len);
        n_txn = 0;
        for (int i = 0; i < 8; i++) begin
            t_addr[3'(i)]  = 'x;
            t_we[3'(i)]    = 1'bx;
            t_wdata[3'(i)] = 'x;
            t_cyc[3'(i)]   = -1;
        end
        for (int i = 0; i < len; i++) begin
            instruction = p[3'(i)];
            ins_valid   = 1'b1;
            ins_last    = (i == len - 1);
            tick();
            if (i == 0) chk("ready_clear_on_first_word", 32'(ready), 32'd0);
        end
        ins_valid   = 1'b0;
        ins_last    = 1'b0;
        instruction = '0;
    endtask

    task automatic run_ready(input int budget, output int cyc);
        int n;
        n = 0;
        while (!ready && n < budget) begin
            tick();
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=0 after %0d cycles expected ready=1", n);
        end
        cyc = n;
    endtask

    initial begin
        prog_t p;
        int    cyc;
        int    n;

        reset       = 1'b0;
        ins_valid   = 1'b0;
        ins_last    = 1'b0;
        instruction = '0;
        mem_valid   = 1'b0;
        mem_rdata   = '0;
        for (int i = 0; i < 4096; i++) smem[12'(i)] = '0;

        vecs[0]  = mkv(li(1, 8'd5),    li(2, 8'd3),   rr(1, 1, 2, 3), rr(13, 0, 0, 3), 4, 8'd8,   12'h000, 18);
        vecs[1]  = mkv(li(1, 8'd200),  li(2, 8'd100), rr(1, 1, 2, 3), rr(13, 0, 0, 3), 4, 8'd44,  12'h000, 18);
        vecs[2]  = mkv(li(1, 8'd200),  rr(4, 1, 0, 4), rr(13, 0, 0, 4), 16'h0, 3, 8'd255, 12'h000, 14);
        vecs[3]  = mkv(li(1, 8'd200),  li(6, 8'd9),   rr(7, 1, 6, 5), rr(13, 0, 0, 5), 4, 8'd0,   12'h000, 18);
        vecs[4]  = mkv(li(1, 8'd3),    li(2, 8'd5),   rr(2, 1, 2, 3), rr(13, 0, 0, 3), 4, 8'd254, 12'h000, 18);
        vecs[5]  = mkv(li(1, 8'd20),   li(2, 8'd13),  rr(3, 1, 2, 3), rr(13, 0, 0, 3), 4, 8'd4,   12'h000, 18);
        vecs[6]  = mkv(li(1, 8'd7),    li(2, 8'd7),   rr(5, 1, 2, 3), rr(13, 0, 0, 3), 4, 8'd1,   12'h000, 18);
        vecs[7]  = mkv(li(1, 8'd6),    li(2, 8'd7),   rr(5, 1, 2, 3), rr(13, 0, 0, 3), 4, 8'd0,   12'h000, 18);
        vecs[8]  = mkv(li(1, 8'h80),   li(2, 8'd7),   rr(6, 1, 2, 3), rr(13, 0, 0, 3), 4, 8'd1,   12'h000, 18);
        vecs[9]  = mkv(li(1, 8'd1),    li(2, 8'd8),   rr(7, 1, 2, 3), rr(13, 0, 0, 3), 4, 8'd0,   12'h000, 18);
        vecs[10] = mkv(li(1, 8'hF0),   li(2, 8'h3C),  rr(10, 1, 2, 3), rr(13, 0, 0, 3), 4, 8'hCC, 12'h000, 18);
        vecs[11] = mkv(li(1, 8'hF0),   li(2, 8'h3C),  rr(8, 1, 2, 3), rr(13, 0, 0, 3), 4, 8'h30,  12'h000, 18);
        vecs[12] = mkv(li(1, 8'hF0),   li(2, 8'h3C),  rr(9, 1, 2, 3), rr(13, 0, 0, 3), 4, 8'hFC,  12'h000, 18);
        vecs[13] = mkv(li(1, 8'd200),  li(2, 8'd7),   rr(4, 1, 2, 3), rr(13, 0, 0, 3), 4, 8'd28,  12'h000, 18);
        vecs[14] = mkv(16'h0807,       rr(13, 0, 0, 7), 16'h0, 16'h0, 2, 8'd9, 12'h000, 10);
        vecs[15] = mkv(li(1, 8'h7F),   li(2, 8'h10),  rr(13, 1, 2, 1), 16'h0, 3, 8'h7F,   12'h07F, 14);

        // Reset values
        tick();
        tick();
        chk("rst_rtr", 32'(rtr), 32'd1);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("core_id", 32'(core_id), 32'd9);
        reset = 1'b1;
        tick();
        chk("post_rst_rtr", 32'(rtr), 32'd1);

        // Three-word program: rtr drops after ins_last, ready 12 cycles later
        p = '0;
        p[0] = li(1, 8'd5);
        p[1] = li(2, 8'd3);
        p[2] = rr(1, 1, 2, 3);
        load_prog(p, 3);
        chk("s1_rtr_low", 32'(rtr), 32'd0);
        run_ready(100, cyc);
        chk("s1_cycles", 32'(cyc), 32'd12);
        chk("s1_rtr_back", 32'(rtr), 32'd1);

        // Table vectors: each ends with a store exposing the result register
        for (int i = 0; i < NV; i++) begin
            load_prog(vecs[i].prog, int'(vecs[i].len));
            run_ready(200, cyc);
            chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
            chk($sformatf("v%0d_ntxn", i), 32'(n_txn), 32'd1);
            chk($sformatf("v%0d_we", i), 32'(t_we[0]), 32'd1);
            chk($sformatf("v%0d_addr", i), 32'(t_addr[0]), 32'(vecs[i].exp_addr));
            chk($sformatf("v%0d_data", i), 32'(t_wdata[0]), 32'(vecs[i].exp_data));
        end

        // Store then load back with 3 extra wait cycles per access
        mem_delay = 3;
        p = '0;
        p[0] = li(1, 8'h7F);
        p[1] = li(2, 8'h10);
        p[2] = li(9, 8'hA5);
        p[3] = rr(13, 1, 2, 9);
        p[4] = rr(11, 1, 2, 10);
        p[5] = rr(13, 0, 0, 10);
        load_prog(p, 6);
        run_ready(300, cyc);
        chk("s2_cycles", 32'(cyc), 32'd36);
        chk("s2_st_we", 32'(t_we[0]), 32'd1);
        chk("s2_st_addr", 32'(t_addr[0]), 32'h07F);
        chk("s2_st_wdata", 32'(t_wdata[0]), 32'hA5);
        chk("s2_st_req_cycles", 32'(t_cyc[0]), 32'd4);
        chk("s2_ld_we", 32'(t_we[1]), 32'd0);
        chk("s2_ld_addr", 32'(t_addr[1]), 32'h07F);
        chk("s2_ld_req_cycles", 32'(t_cyc[1]), 32'd4);
        chk("s2_ld_value", 32'(t_wdata[2]), 32'hA5);
        mem_delay = 1;

        // Countdown loop: sub runs three times
        p = '0;
        p[0] = li(2, 8'd1);
        p[1] = li(1, 8'd3);
        p[2] = rr(2, 1, 2, 1);
        p[3] = rr(14, 1, 2, 0);
        p[4] = rr(13, 0, 0, 1);
        load_prog(p, 5);
        run_ready(300, cyc);
        chk("s3_cycles", 32'(cyc), 32'd38);
        chk("s3_r1_final", 32'(t_wdata[0]), 32'd0);

        // Branch beyond program length ends immediately; following li skipped
        p = '0;
        p[0] = li(3, 8'h11);
        p[1] = li(1, 8'd1);
        p[2] = rr(14, 1, 9, 0);
        p[3] = li(3, 8'h55);
        load_prog(p, 4);
        run_ready(100, cyc);
        chk("s3b_cycles", 32'(cyc), 32'd12);
        p = '0;
        p[0] = rr(13, 0, 0, 3);
        load_prog(p, 1);
        run_ready(100, cyc);
        chk("s3b_r3_kept", 32'(t_wdata[0]), 32'h11);

        // cid then halt; instruction after halt must not execute
        p = '0;
        p[0] = li(8, 8'h22);
        load_prog(p, 1);
        run_ready(100, cyc);
        chk("s4_one_word_cycles", 32'(cyc), 32'd4);
        chk("s4_ready_held", 32'(ready), 32'd1);
        p = '0;
        p[0] = 16'h0807;
        p[1] = 16'hF000;
        p[2] = li(8, 8'd1);
        load_prog(p, 3);
        run_ready(100, cyc);
        chk("s4_halt_cycles", 32'(cyc), 32'd8);
        p = '0;
        p[0] = rr(13, 0, 0, 7);
        p[1] = rr(13, 0, 0, 8);
        load_prog(p, 2);
        run_ready(100, cyc);
        chk("s4_r7_cid", 32'(t_wdata[0]), 32'd9);
        chk("s4_r8_unchanged", 32'(t_wdata[1]), 32'h22);

        // Reset while waiting on memory
        resp_en = 1'b0;
        p = '0;
        p[0] = li(5, 8'h33);
        p[1] = rr(13, 0, 0, 5);
        load_prog(p, 2);
        n = 0;
        while (!mem_req && n < 50) begin
            tick();
            n++;
        end
        chk("s5_req_seen", 32'(mem_req), 32'd1);
        tick();
        tick();
        chk("s5_req_held", 32'(mem_req), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("s5_async_mem_req", 32'(mem_req), 32'd0);
        chk("s5_async_rtr", 32'(rtr), 32'd1);
        chk("s5_async_ready", 32'(ready), 32'd0);
        chk("s5_async_addr", 32'(mem_addr), 32'd0);
        #1 reset = 1'b1;
        mem_valid = 1'b1;
        tick();
        tick();
        chk("s5_late_valid_rtr", 32'(rtr), 32'd1);
        chk("s5_late_valid_req", 32'(mem_req), 32'd0);
        chk("s5_late_valid_ready", 32'(ready), 32'd0);
        resp_en = 1'b1;
        p = '0;
        p[0] = rr(13, 0, 0, 5);
        load_prog(p, 1);
        run_ready(100, cyc);
        chk("s5_rf_cleared", 32'(t_wdata[0]), 32'd0);
        chk("s5_cycles", 32'(cyc), 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
